pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the event counters.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1, SHALL be the reset: synchronous, active-high.
REQ-004 Ports RA1D, RA2D, input, 4 each, SHALL carry the source register indices of the instruction in decode.
REQ-005 Ports WA3E, WA3M, WA3W, input, 4 each, SHALL carry the destination index of the instruction in EX, MEM and WB.
REQ-006 Ports RegWriteE, RegWriteM, RegWriteW, input, 1 each, SHALL carry the write enable per stage.
REQ-007 Port MemtoRegE, input, 1, SHALL flag a load in EX.
REQ-008 Port BranchTakenE, input, 1, SHALL flag a branch resolved taken in EX.
REQ-009 Ports StallF, StallD, FlushD, FlushE, output, 1 each, SHALL be the hold/clear controls for the IF/ID and ID/EX segment registers.
REQ-010 Ports ForwardAE, ForwardBE, output, 2 each, SHALL select the ALU operand source: 00 register file, 01 WB result, 10 MEM result.
REQ-011 Ports StallCount, FlushCount, output, CNT_W each, SHALL report the stall and flush events since reset.

Function
REQ-012 A register match SHALL require an equal index, an asserted RegWrite for that stage, and an index other than 15 (PC); index 15 SHALL never match.
REQ-013 Forwarding SHALL give MEM priority over WB when both match; with no match the output SHALL be 00.
REQ-014 The FSM SHALL have three states: RUN, LDSTALL and BFLUSH.
REQ-015 RUN to LDSTALL: MemtoRegE=1 and WA3E matches RA1D or RA2D; StallF=StallD=FlushE=1 in that same cycle.
REQ-016 LDSTALL SHALL last exactly 1 cycle and then return to RUN with all stall/flush outputs 0 unless a new hazard is detected.
REQ-017 RUN or LDSTALL to BFLUSH: BranchTakenE=1; FlushD=FlushE=1 in that cycle, with StallF=StallD=0.
REQ-018 BFLUSH SHALL last exactly 1 cycle, then return to RUN.
REQ-019 When BranchTakenE and a load-use hazard occur in the same cycle, the branch SHALL win: no stall is asserted and no stall is counted.
REQ-020 StallCount SHALL increment by 1 per cycle with StallD=1; FlushCount SHALL increment by 1 per cycle with FlushE=1 caused by a branch.
REQ-021 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.

Reset
REQ-022 While rst=1: state=RUN, all stall/flush outputs 0, ForwardAE=ForwardBE=00, both counters 0.
REQ-023 A rst asserted during LDSTALL or BFLUSH SHALL abort the operation.
REQ-024 The first cycle after rst deasserts SHALL evaluate hazards from RUN.

Configuration
REQ-025 With HAZARD_FWD_EN defined, forwarding SHALL operate per REQ-013, and only load-use hazards SHALL stall.
REQ-026 Without HAZARD_FWD_EN, ForwardAE=ForwardBE=00 constantly.
REQ-027 Without HAZARD_FWD_EN, any source match against EX or MEM SHALL cause StallF=StallD=FlushE=1, repeating each cycle until the writer reaches WB.
REQ-028 Without HAZARD_FWD_EN, the register file SHALL write in the first half-cycle, so a WB match SHALL NOT stall.

Structure
REQ-029 Package hazard_pkg SHALL hold the state enum (RUN, LDSTALL, BFLUSH), the fwd_sel_t enum (FWD_RF=00, FWD_WB=01, FWD_MEM=10) and the constant PC_IDX=15.
REQ-030 The saturating counter SHALL be the sub-module sat_counter, instantiated twice.

Verification
REQ-031 Scenario: RA1D=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10, no stall.
REQ-032 Scenario: MemtoRegE=1, RegWriteE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 for 1 cycle, then RUN; StallCount=1.
REQ-033 Scenario: load-use hazard together with BranchTakenE=1 -> FlushD=FlushE=1, StallD=0, FlushCount=1, StallCount=0.
REQ-034 Scenario: WA3E=15, RegWriteE=1, MemtoRegE=1, RA1D=15 -> no stall, ForwardAE=00.
REQ-035 Scenario: CNT_W=4 with 20 consecutive stall cycles -> StallCount holds at 15.
REQ-036 Scenario: rst asserted in the LDSTALL cycle -> the next cycle shows all outputs 0 and state RUN.
REQ-037 Scenario: without HAZARD_FWD_EN, an ALU writer to r2 followed by a reader of r2 -> 2 stall cycles, and ForwardAE stays 00 throughout.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Holds the controller state enum, the forwarding-select enum, the PC
// register index and the register-match / forward-select helpers.
package hazard_pkg;

  // Controller state: normal issue, one-cycle load-use stall, one-cycle branch flush
  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    BFLUSH  = 2'b10
  } state_t;

  // ALU operand source select
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // r15 is the PC; it is never produced by a pipeline writer
  localparam logic [3:0] PC_IDX = 4'd15;

  // A source depends on a stage's writer only if that writer really writes
  // a general-purpose register with the same index.
  function automatic logic reg_match(input logic [3:0] src,
                                     input logic [3:0] dst,
                                     input logic       we);
    return we && (src == dst) && (dst != PC_IDX);
  endfunction

  // MEM holds the younger result, so it wins when both later stages match.
  function automatic fwd_sel_t fwd_select(input logic mem_hit,
                                          input logic wb_hit);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at its all-ones value.
// Cleared by a synchronous active-high reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count one per cycle with inc high, holding once the maximum is reached
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard detection, stall/flush control and operand
// forwarding for a five-stage pipeline, with saturating stall/flush counters.
// Optional feature macro: HAZARD_FWD_EN
//   defined   -> MEM/WB forwarding active, only load-use hazards stall
//   undefined -> no forwarding, any EX/MEM source match stalls
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             BranchTakenE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  state_t   state;
  state_t   state_next;

  logic     match_e1;
  logic     match_e2;
  logic     match_m1;
  logic     match_m2;
  logic     load_use;
  logic     hazard;
  logic     branch_flush;
  fwd_sel_t fwd_a;
  fwd_sel_t fwd_b;

  // Source/destination comparisons against the EX and MEM writers
  always_comb begin
    match_e1 = reg_match(RA1D, WA3E, RegWriteE);
    match_e2 = reg_match(RA2D, WA3E, RegWriteE);
    match_m1 = reg_match(RA1D, WA3M, RegWriteM);
    match_m2 = reg_match(RA2D, WA3M, RegWriteM);
    load_use = MemtoRegE && (match_e1 || match_e2);
  end

`ifdef HAZARD_FWD_EN
  logic match_w1;
  logic match_w2;

  // With forwarding, ALU results bypass from MEM/WB and only a load in EX stalls
  always_comb begin
    match_w1 = reg_match(RA1D, WA3W, RegWriteW);
    match_w2 = reg_match(RA2D, WA3W, RegWriteW);
    fwd_a    = fwd_select(match_m1, match_w1);
    fwd_b    = fwd_select(match_m2, match_w2);
    hazard   = load_use;
  end
`else
  logic unused_wb;

  // The register file writes in the first half-cycle, so WB needs no handling
  assign unused_wb = ^{WA3W, RegWriteW};

  // Without forwarding every EX/MEM dependence stalls until the writer reaches WB
  always_comb begin
    fwd_a  = FWD_RF;
    fwd_b  = FWD_RF;
    hazard = load_use || match_e1 || match_e2 || match_m1 || match_m2;
  end
`endif

  // Next state is decided afresh every cycle, so each stall or flush lasts one cycle
  // unless the inputs present a new hazard; a taken branch always wins.
  always_comb begin
    state_next = RUN;
    case (state)
      RUN, LDSTALL, BFLUSH: begin
        if (BranchTakenE) begin
          state_next = BFLUSH;
        end else if (hazard) begin
          state_next = LDSTALL;
        end else begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // State register; reset aborts any stall or flush in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Segment-register controls act in the detecting cycle and are silenced by reset
  always_comb begin
    StallF       = 1'b0;
    StallD       = 1'b0;
    FlushD       = 1'b0;
    FlushE       = 1'b0;
    branch_flush = 1'b0;
    if (!rst) begin
      if (BranchTakenE) begin
        FlushD       = 1'b1;
        FlushE       = 1'b1;
        branch_flush = 1'b1;
      end else if (hazard) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // Operand selects are forced to the register file while in reset
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (!rst) begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (StallD),
    .count (StallCount)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (branch_flush),
    .count (FlushCount)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed scenarios followed by random
// traffic, all checked against a rule-level reference model. A second
// instance with 4-bit counters exercises saturation on the same stimulus.
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  RA1D, RA2D, WA3E, WA3M, WA3W;
  logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, BranchTakenE;

  logic        StallF, StallD, FlushD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] StallCount, FlushCount;

  logic        n_stall_f, n_stall_d, n_flush_d, n_flush_e;
  logic [1:0]  n_fwd_a, n_fwd_b;
  logic [3:0]  n_stall_cnt, n_flush_cnt;

  int checks   = 0;
  int failures = 0;
  int mdl_stall;
  int mdl_flush;
  int mdl_stall4;
  int mdl_flush4;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .RA1D(RA1D), .RA2D(RA2D),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .RA1D(RA1D), .RA2D(RA2D),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE),
    .StallF(n_stall_f), .StallD(n_stall_d), .FlushD(n_flush_d), .FlushE(n_flush_e),
    .ForwardAE(n_fwd_a), .ForwardBE(n_fwd_b),
    .StallCount(n_stall_cnt), .FlushCount(n_flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic depends(input logic [3:0] src, input logic [3:0] dst, input logic we);
    return we && (src == dst) && (src != 4'd15);
  endfunction

  function automatic int sat_add(input int value, input int limit);
    return (value >= limit) ? limit : value + 1;
  endfunction

  task automatic clearInputs();
    RA1D = 4'd0; RA2D = 4'd0; WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b0; BranchTakenE = 1'b0;
  endtask

  task automatic applyStimulus();
    RA1D = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    RA2D = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    WA3E = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    WA3M = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    WA3W = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    RegWriteE    = ($urandom_range(0, 3) != 0);
    RegWriteM    = ($urandom_range(0, 3) != 0);
    RegWriteW    = ($urandom_range(0, 3) != 0);
    MemtoRegE    = ($urandom_range(0, 2) == 0);
    BranchTakenE = ($urandom_range(0, 7) == 0);
    rst          = ($urandom_range(0, 39) == 0);
  endtask

  // Reference model: outputs from the hazard rules, counters as plain integers
  task automatic checkOutput(input string tag);
    logic       load_dep, any_dep, stall_need, br;
    logic       e_stall, e_flush_d, e_flush_e;
    logic [1:0] e_fa, e_fb;
    br       = BranchTakenE;
    load_dep = MemtoRegE && (depends(RA1D, WA3E, RegWriteE) || depends(RA2D, WA3E, RegWriteE));
    any_dep  = depends(RA1D, WA3E, RegWriteE) || depends(RA2D, WA3E, RegWriteE) ||
               depends(RA1D, WA3M, RegWriteM) || depends(RA2D, WA3M, RegWriteM);
`ifdef HAZARD_FWD_EN
    stall_need = load_dep;
    e_fa = depends(RA1D, WA3M, RegWriteM) ? 2'b10 : depends(RA1D, WA3W, RegWriteW) ? 2'b01 : 2'b00;
    e_fb = depends(RA2D, WA3M, RegWriteM) ? 2'b10 : depends(RA2D, WA3W, RegWriteW) ? 2'b01 : 2'b00;
`else
    stall_need = any_dep;
    e_fa = 2'b00;
    e_fb = 2'b00;
`endif
    if (rst) begin
      e_fa = 2'b00;
      e_fb = 2'b00;
    end
    e_stall   = !rst && !br && stall_need;
    e_flush_d = !rst && br;
    e_flush_e = !rst && (br || stall_need);

    check({tag, ".StallF"},     StallF,     e_stall);
    check({tag, ".StallD"},     StallD,     e_stall);
    check({tag, ".FlushD"},     FlushD,     e_flush_d);
    check({tag, ".FlushE"},     FlushE,     e_flush_e);
    check({tag, ".ForwardAE"},  ForwardAE,  e_fa);
    check({tag, ".ForwardBE"},  ForwardBE,  e_fb);
    check({tag, ".StallCount"}, StallCount, mdl_stall);
    check({tag, ".FlushCount"}, FlushCount, mdl_flush);
    check({tag, ".StallD4"},    n_stall_d,  e_stall);
    check({tag, ".StallCnt4"},  n_stall_cnt, mdl_stall4);
    check({tag, ".FlushCnt4"},  n_flush_cnt, mdl_flush4);

    if (rst) begin
      mdl_stall = 0; mdl_flush = 0; mdl_stall4 = 0; mdl_flush4 = 0;
    end else begin
      if (e_stall) begin
        mdl_stall  = sat_add(mdl_stall, 65535);
        mdl_stall4 = sat_add(mdl_stall4, 15);
      end
      if (e_flush_d) begin
        mdl_flush  = sat_add(mdl_flush, 65535);
        mdl_flush4 = sat_add(mdl_flush4, 15);
      end
    end
  endtask

  task automatic runCycle(input string tag);
    @(negedge clk);
    checkOutput(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    clearInputs();
    rst = 1'b1;
    runCycle("reset");
    rst = 1'b0;
  endtask

  // Directed scenarios followed by randomized traffic
  initial begin
    clearInputs();
    rst = 1'b1;
    mdl_stall = 0; mdl_flush = 0; mdl_stall4 = 0; mdl_flush4 = 0;
    @(posedge clk);
    #1;

    $display("[TB] reset behaviour");
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA1D = 4'd5; BranchTakenE = 1'b1;
    RegWriteM = 1'b1; WA3M = 4'd2; RA2D = 4'd2;
    #1;
    check("rst.StallD", StallD, 1'b0);
    check("rst.FlushE", FlushE, 1'b0);
    check("rst.ForwardBE", ForwardBE, 2'b00);
    check("rst.state", dut.state, RUN);
    runCycle("rst_hold");
    resetDut();

    $display("[TB] forwarding priority");
    RA1D = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1;
    #1;
`ifdef HAZARD_FWD_EN
    check("fwd.ForwardAE", ForwardAE, 2'b10);
    check("fwd.StallD", StallD, 1'b0);
`else
    check("nofwd.ForwardAE", ForwardAE, 2'b00);
    check("nofwd.StallD", StallD, 1'b1);
`endif
    runCycle("fwd");

    $display("[TB] load-use stall");
    resetDut();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA2D = 4'd5; RA1D = 4'd1;
    #1;
    check("ld.StallF", StallF, 1'b1);
    check("ld.StallD", StallD, 1'b1);
    check("ld.FlushE", FlushE, 1'b1);
    check("ld.FlushD", FlushD, 1'b0);
    runCycle("ld");
    clearInputs();
    #1;
    check("ld.state1", dut.state, LDSTALL);
    check("ld.StallD1", StallD, 1'b0);
    check("ld.StallCount", StallCount, 16'd1);
    runCycle("ld_after");
    check("ld.state2", dut.state, RUN);

    $display("[TB] branch beats load-use");
    resetDut();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA1D = 4'd5; BranchTakenE = 1'b1;
    #1;
    check("br.FlushD", FlushD, 1'b1);
    check("br.FlushE", FlushE, 1'b1);
    check("br.StallD", StallD, 1'b0);
    check("br.StallF", StallF, 1'b0);
    runCycle("br");
    clearInputs();
    #1;
    check("br.state1", dut.state, BFLUSH);
    check("br.FlushCount", FlushCount, 16'd1);
    check("br.StallCount", StallCount, 16'd0);
    runCycle("br_after");
    check("br.state2", dut.state, RUN);

    $display("[TB] PC index never matches");
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd15; RA1D = 4'd15;
    RegWriteM = 1'b1; WA3M = 4'd15;
    #1;
    check("pc.StallD", StallD, 1'b0);
    check("pc.ForwardAE", ForwardAE, 2'b00);
    runCycle("pc");

    $display("[TB] reset during stall");
    resetDut();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd7; RA1D = 4'd7;
    runCycle("rs_ld");
    rst = 1'b1;
    #1;
    check("rs.StallD", StallD, 1'b0);
    check("rs.FlushE", FlushE, 1'b0);
    runCycle("rs_hold");
    rst = 1'b0;
    clearInputs();
    #1;
    check("rs.state", dut.state, RUN);
    check("rs.StallF", StallF, 1'b0);
    check("rs.StallCount", StallCount, 16'd0);
    runCycle("rs_after");

`ifndef HAZARD_FWD_EN
    $display("[TB] ALU dependence without forwarding");
    resetDut();
    RegWriteE = 1'b1; WA3E = 4'd2; RA1D = 4'd2;
    #1;
    check("alu.StallD0", StallD, 1'b1);
    runCycle("alu0");
    clearInputs();
    RegWriteM = 1'b1; WA3M = 4'd2; RA1D = 4'd2;
    #1;
    check("alu.StallD1", StallD, 1'b1);
    check("alu.ForwardAE1", ForwardAE, 2'b00);
    runCycle("alu1");
    clearInputs();
    RegWriteW = 1'b1; WA3W = 4'd2; RA1D = 4'd2;
    #1;
    check("alu.StallD2", StallD, 1'b0);
    check("alu.ForwardAE2", ForwardAE, 2'b00);
    check("alu.StallCount", StallCount, 16'd2);
    runCycle("alu2");
`endif

    $display("[TB] counter saturation");
    resetDut();
    for (int i = 0; i < 20; i++) begin
      MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd4; RA2D = 4'd4;
      runCycle("sat");
    end
    clearInputs();
    #1;
    check("sat.StallCnt4", n_stall_cnt, 4'd15);
    check("sat.StallCnt16", StallCount, 16'd20);
    runCycle("sat_after");

    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++) begin
      applyStimulus();
      runCycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
